// File: rtl/rank_filter_core.sv
// Rank-order selector: sorts an N-sample window through an N-stage odd-even transposition network, returns the requested rank.
// Latency: N+1 cycles from input sample edge to oValid; one window per clock.
// Backpressure: none; bubbles (iValid=0) travel as invalid slots, reset discards everything in flight.
module rank_filter_core #(
    parameter int WIDTH  = 8,
    parameter int N      = 9,
    parameter int RANK_W = 5
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iValid,
    input  logic [N*WIDTH-1:0]   iData,
    input  logic [RANK_W-1:0]    iRank,
    input  logic [1:0]           iMode,
    output logic                 oValid,
    output logic [WIDTH-1:0]     oValue,
    output logic                 oRankErr
);

    localparam logic [RANK_W-1:0] RANK_ONE = RANK_W'(1);
    localparam logic [RANK_W-1:0] RANK_MED = RANK_W'((N + 1) / 2);
    localparam logic [RANK_W-1:0] RANK_MAX = RANK_W'(N);

    // Stage 0 holds the captured window; stage N holds the fully sorted window.
    logic [N*WIDTH-1:0] stg_dat  [0:N];
    logic [RANK_W-1:0]  stg_rank [0:N];
    logic [N:0]         stg_err;
    logic [N:0]         stg_vld;

    logic [RANK_W-1:0]  cap_rank;
    logic               cap_err;
    logic [RANK_W-1:0]  sel_idx;
    logic [WIDTH-1:0]   sel_val;

    // One transposition step: odd steps pair (0,1),(2,3)..; even steps pair (1,2),(3,4)..
    function automatic logic [N*WIDTH-1:0] cx_stage(input logic [N*WIDTH-1:0] v, input logic odd);
        logic [N*WIDTH-1:0] r;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        r = v;
        for (int k = 0; k < N - 1; k++) begin
            if (k[0] != odd) begin
                a = v[k*WIDTH +: WIDTH];
                b = v[(k+1)*WIDTH +: WIDTH];
                if (a > b) begin
                    r[k*WIDTH +: WIDTH]     = b;
                    r[(k+1)*WIDTH +: WIDTH] = a;
                end
            end
        end
        return r;
    endfunction

    // Decode the effective rank for the window being captured, clamping out-of-range requests.
    always_comb begin
        cap_rank = RANK_ONE;
        cap_err  = 1'b0;
        case (iMode)
            2'b00: begin
                if (iRank == '0) begin
                    cap_rank = RANK_ONE;
                    cap_err  = 1'b1;
                end else if (iRank > RANK_MAX) begin
                    cap_rank = RANK_MAX;
                    cap_err  = 1'b1;
                end else begin
                    cap_rank = iRank;
                end
            end
            2'b01:   cap_rank = RANK_MED;
            2'b10:   cap_rank = RANK_ONE;
            default: cap_rank = RANK_MAX;
        endcase
    end

    // Data, rank and error travel down the sorting pipeline; contents are don't-care until valid.
    always_ff @(posedge iClk) begin
        stg_dat[0]  <= iData;
        stg_rank[0] <= cap_rank;
        stg_err[0]  <= cap_err;
        for (int s = 1; s <= N; s++) begin
            stg_dat[s]  <= cx_stage(stg_dat[s-1], s[0]);
            stg_rank[s] <= stg_rank[s-1];
            stg_err[s]  <= stg_err[s-1];
        end
    end

    // Valid bits are the only reset pipeline state, so reset flushes all in-flight windows.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stg_vld <= '0;
        end else begin
            stg_vld <= {stg_vld[N-1:0], iValid};
        end
    end

    // Pick the requested rank out of the sorted vector; clamping keeps the index within 0..N-1.
    always_comb begin
        sel_idx = stg_rank[N] - RANK_ONE;
        sel_val = stg_dat[N][sel_idx*WIDTH +: WIDTH];
    end

    // Output register: update on a valid slot, otherwise hold value/error and drop valid.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oValid   <= 1'b0;
            oValue   <= '0;
            oRankErr <= 1'b0;
        end else if (stg_vld[N]) begin
            oValid   <= 1'b1;
            oValue   <= sel_val;
            oRankErr <= stg_err[N];
        end else begin
            oValid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rank_filter_core.sv
// Bench for rank_filter_core (N=9, WIDTH=8): directed vectors with literal expectations plus a sorting reference model.
// The model queues each accepted window's answer with its due cycle; a compare process checks outputs every cycle.
// Reset empties the model queue, mirroring the discard of in-flight windows.
module tb_rank_filter_core;

    localparam int W  = 8;
    localparam int N  = 9;
    localparam int RW = 5;

    logic           iClk   = 1'b0;
    logic           iRst   = 1'b1;
    logic           iValid = 1'b0;
    logic [N*W-1:0] iData  = '0;
    logic [RW-1:0]  iRank  = '0;
    logic [1:0]     iMode  = '0;
    logic           oValid;
    logic [W-1:0]   oValue;
    logic           oRankErr;

    rank_filter_core #(.WIDTH(W), .N(N), .RANK_W(RW)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iData(iData),
        .iRank(iRank), .iMode(iMode), .oValid(oValid), .oValue(oValue),
        .oRankErr(oRankErr)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit comp_en = 1'b0;

    typedef struct { int due; int v; int e; } exp_t;
    typedef struct { int c; int v; int e; } log_t;
    exp_t pend[$];
    log_t out_log[$];
    int   exp_vld = 0;
    int   exp_val = 0;
    int   exp_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: sort the window plainly and take the rank-th smallest.
    function automatic int pick(input logic [N*W-1:0] d, input int rk);
        int a[N];
        int t;
        for (int i = 0; i < N; i++) a[i] = int'(d[i*W +: W]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[rk-1];
    endfunction

    function automatic logic [N*W-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int a[N];
        logic [N*W-1:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i][W-1:0];
        return r;
    endfunction

    // Model: the output for a window accepted at cycle c appears at cycle c+N+1.
    always @(posedge iClk) begin
        int rk;
        int er;
        cyc++;
        if (iRst) begin
            pend.delete();
            exp_vld = 0;
            exp_val = 0;
            exp_err = 0;
            comp_en = 1'b1;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_vld = 1;
                exp_val = pend[0].v;
                exp_err = pend[0].e;
                void'(pend.pop_front());
            end else begin
                exp_vld = 0;
            end
            if (iValid) begin
                er = 0;
                case (iMode)
                    2'b00: begin
                        rk = int'(iRank);
                        if (rk == 0) begin rk = 1; er = 1; end
                        else if (rk > N) begin rk = N; er = 1; end
                    end
                    2'b01:   rk = (N + 1) / 2;
                    2'b10:   rk = 1;
                    default: rk = N;
                endcase
                pend.push_back('{cyc + N + 1, pick(iData, rk), er});
            end
        end
    end

    // Compare every cycle away from the active edge; log valid outputs for the directed checks.
    always @(negedge iClk) begin
        if (comp_en) begin
            chk("ovalid", 32'(oValid), 32'(exp_vld));
            chk("ovalue", 32'(oValue), 32'(exp_val));
            chk("orankerr", 32'(oRankErr), 32'(exp_err));
            if (oValid === 1'b1) out_log.push_back('{cyc, int'(oValue), int'(oRankErr)});
        end
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // After put() returns, cyc is the cycle at which the window was sampled.
    task automatic put(input bit v, input logic [N*W-1:0] d, input int r, input int m);
        iValid = v;
        iData  = d;
        iRank  = r[RW-1:0];
        iMode  = m[1:0];
        step();
    endtask

    task automatic idle(input int n);
        iValid = 1'b0;
        repeat (n) step();
    endtask

    task automatic expect_at(input string nm, input int c, input int v, input int e);
        int found;
        int idx;
        found = 0;
        idx   = 0;
        foreach (out_log[i]) if (out_log[i].c == c) begin found = 1; idx = i; end
        chk({nm, "_present"}, 32'(found), 32'd1);
        if (found == 1) begin
            chk({nm, "_value"}, 32'(out_log[idx].v), 32'(v));
            chk({nm, "_err"}, 32'(out_log[idx].e), 32'(e));
        end
    endtask

    function automatic logic [N*W-1:0] rnd_win(input bit narrow);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            r[i*W +: W] = narrow ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
        return r;
    endfunction

    logic [N*W-1:0] dset;
    logic [N*W-1:0] tset;
    int c0;
    int b0;

    initial begin
        dset = pk(200, 3, 77, 3, 150, 0, 255, 90, 42);
        tset = pk(128, 128, 128, 128, 128, 128, 128, 128, 128);

        // Reset held two cycles with valid random windows offered.
        iRst = 1'b1; iValid = 1'b1; iData = rnd_win(1'b0);
        step();
        iData = rnd_win(1'b0);
        step();
        iRst = 1'b0;
        idle(1);
        chk("reset_ovalid", 32'(oValid), 32'd0);
        chk("reset_ovalue", 32'(oValue), 32'd0);
        chk("reset_orankerr", 32'(oRankErr), 32'd0);
        idle(11);
        chk("reset_no_output", 32'(out_log.size()), 32'd0);

        // Median of reverse-ordered window.
        out_log.delete();
        put(1'b1, pk(9, 8, 7, 6, 5, 4, 3, 2, 1), 0, 1);
        c0 = cyc;
        idle(13);
        expect_at("median", c0 + 10, 5, 0);
        chk("median_count", 32'(out_log.size()), 32'd1);

        // Modes and ranks back-to-back.
        out_log.delete();
        put(1'b1, dset, 0, 2);
        c0 = cyc;
        put(1'b1, dset, 0, 3);
        put(1'b1, dset, 3, 0);
        put(1'b1, dset, 4, 0);
        idle(13);
        expect_at("mode_min", c0 + 10, 0, 0);
        expect_at("mode_max", c0 + 11, 255, 0);
        expect_at("rank3", c0 + 12, 3, 0);
        expect_at("rank4", c0 + 13, 42, 0);
        chk("modes_count", 32'(out_log.size()), 32'd4);

        // Clamping.
        out_log.delete();
        put(1'b1, dset, 0, 0);
        c0 = cyc;
        put(1'b1, dset, 13, 0);
        put(1'b1, dset, 9, 0);
        idle(13);
        expect_at("clamp_rank0", c0 + 10, 0, 1);
        expect_at("clamp_rank13", c0 + 11, 255, 1);
        expect_at("rank9", c0 + 12, 255, 0);

        // Ties: every rank of an all-128 window.
        out_log.delete();
        for (int r = 1; r <= N; r++) begin
            put(1'b1, tset, r, 0);
            if (r == 1) c0 = cyc;
        end
        idle(13);
        for (int r = 1; r <= N; r++) expect_at("ties", c0 + r - 1 + 10, 128, 0);

        // Bubbles, then reset mid-flight, then one fresh window.
        out_log.delete();
        put(1'b1, dset, 0, 1);
        b0 = cyc;
        put(1'b0, dset, 0, 1);
        put(1'b1, dset, 0, 1);
        put(1'b1, dset, 0, 1);
        put(1'b0, dset, 0, 1);
        iRst = 1'b1;
        put(1'b0, dset, 0, 1);
        iRst = 1'b0;
        put(1'b0, dset, 0, 1);
        put(1'b1, dset, 0, 1);
        idle(14);
        chk("flush_count", 32'(out_log.size()), 32'd1);
        expect_at("after_reset", b0 + 17, 77, 0);

        // Random windows with random mode/rank, occasional bubbles and narrow (tie-heavy) data.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) idle(1);
            put(1'b1, rnd_win($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)));
        end
        idle(14);
        chk("model_drained", 32'(pend.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
